date_counter: RTL and testbench
===============================

Name: date_counter

Overview:
- Calendar stage directly downstream of the hour counter in the millennium clock.
- Consumes the hour stage's day-overflow pulse and advances day/month/year with Gregorian month lengths and leap years.
- Supports manual adjustment of one field at a time using up/down buttons.
- Feeds the display/BCD stage; asserts a one-cycle pulse on millennium wrap.

Parameters:
- YEAR_MIN, 1, lowest representable year.
- YEAR_MAX, 9999, highest year; increment past it wraps to YEAR_MIN.
- RESET_YEAR, 2000, year loaded on reset.

Ports:
- clk_1Hz  in  1  system tick clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- en_1  in  1  count enable.
- adjust  in  1  0: count mode, 1: adjust mode.
- sel  in  2  adjust field: 0 day, 1 month, 2 year, 3 none.
- up  in  1  level button, synchronous to clk_1Hz; its rising edge steps the selected field +1.
- down  in  1  level button, synchronous; its rising edge steps the selected field -1.
- carry_in  in  1  day-overflow pulse from the hour stage.
- day_bin  out  5  day of month, 1..31.
- month_bin  out  4  month, 1..12.
- year_bin  out  14  year, YEAR_MIN..YEAR_MAX.
- leap  out  1  current year is a leap year (combinational from year_bin).
- carry_out  out  1  one-cycle pulse on YEAR_MAX→YEAR_MIN wrap.

Behaviour:
- Clocking/reset: one clock (clk_1Hz); reset is asynchronous and active-low (rst_n).
- Reset values: day_bin=1, month_bin=1, year_bin=RESET_YEAR, carry_out=0, up_q=0, down_q=0.
- Edge detect: up_q and down_q register up and down every cycle.
  - up_rise = up & ~up_q; down_rise = down & ~down_q.
  - The field changes at the same clock edge where the rise is sampled.
- Days in month (dim): 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; month 2 is 29 if leap, else 28.
- Count mode (adjust=0, en_1=1, carry_in=1), evaluated at the edge:
  - day<dim: day+1.
  - day==dim: day=1, then the month rolls.
  - Month roll: month<12: month+1; month==12: month=1, then the year rolls.
  - Year roll: year<YEAR_MAX: year+1; else year=YEAR_MIN and carry_out=1 for exactly this cycle.
  - carry_out=0 in every other cycle.
- carry_in while adjust=1 or en_1=0: dropped, not queued; no state change.
- Adjust mode (adjust=1):
  - up_rise & down_rise in the same cycle: no change.
  - sel=0: day steps 1..dim with wrap (dim→1, 1→dim).
  - sel=1: month steps 1..12 with wrap.
  - sel=2: year steps YEAR_MIN..YEAR_MAX with wrap.
  - sel=3: no change.
  - carry_out is never asserted in adjust mode.
- Clamp: after any month or year change (count or adjust), if day > new dim then day=new dim in the same edge. Example: 31 Mar with month-- gives 28/29 Feb.
- Button rises while adjust=0: ignored, but up_q/down_q still track.
- Mode switch: adjust 0→1 or 1→0 mid-operation causes no field change; in-progress edges are evaluated against the new mode.
- Reset mid-operation: all state returns to reset values immediately.

Optional Feature:
- Macro: DATE_GREGORIAN_400_EN.
- Defined: leap = (y%4==0 && y%100!=0) || y%400==0.
- Undefined: leap = (y%4==0) only (Julian-style, smaller logic).
- Both builds: leap is derived combinationally from year_bin.

Decomposition:
- Shared package date_pkg holds:
  - month constants MON_JAN..MON_DEC;
  - field-select encodings SEL_DAY, SEL_MONTH, SEL_YEAR, SEL_NONE;
  - widths DAY_W=5, MON_W=4, YEAR_W=14.
- One combinational sub-module, days_in_month:
  - inputs month, leap; output dim (5 bits);
  - instantiated twice: once for the current month/year, once for the next month/year used by the clamp.

Test Plan:
- Reset → day 1, month 1, year 2000, carry_out 0; 31 carry_in pulses → 1 Feb 2000.
- Leap year: 28 Feb 2000 + 1 pulse → 29 Feb; 28 Feb 1900 + 1 → 29 Feb with macro undefined, 1 Mar with macro defined; 28 Feb 2023 + 1 → 1 Mar.
- 31 Dec 9999 + carry_in → 1 Jan 0001 with carry_out high exactly one cycle; 31 Dec 2024 → 1 Jan 2025 with carry_out 0.
- Adjust: day 31, month 3, sel=1, one down rise → month 2, day 29 (year 2024); up held high 5 cycles → a single step.
- Adjust conflicts: up and down rising together → no change; carry_in during adjust=1 → dropped (date unchanged after adjust returns to 0).
- Async reset asserted mid-count with day 15, month 7 → outputs return to 1/1/2000 without a clock edge.

Source files
------------

// File: rtl/date_pkg.sv
// Shared calendar constants, field-select encodings and the leap-year rule.
// Define DATE_GREGORIAN_400_EN for the full Gregorian rule; default is divisible-by-4.
package date_pkg;

  localparam int unsigned DAY_W  = 5;
  localparam int unsigned MON_W  = 4;
  localparam int unsigned YEAR_W = 14;

  localparam logic [MON_W-1:0] MON_JAN = 4'd1;
  localparam logic [MON_W-1:0] MON_FEB = 4'd2;
  localparam logic [MON_W-1:0] MON_MAR = 4'd3;
  localparam logic [MON_W-1:0] MON_APR = 4'd4;
  localparam logic [MON_W-1:0] MON_MAY = 4'd5;
  localparam logic [MON_W-1:0] MON_JUN = 4'd6;
  localparam logic [MON_W-1:0] MON_JUL = 4'd7;
  localparam logic [MON_W-1:0] MON_AUG = 4'd8;
  localparam logic [MON_W-1:0] MON_SEP = 4'd9;
  localparam logic [MON_W-1:0] MON_OCT = 4'd10;
  localparam logic [MON_W-1:0] MON_NOV = 4'd11;
  localparam logic [MON_W-1:0] MON_DEC = 4'd12;

  typedef enum logic [1:0] {
    SEL_DAY   = 2'd0,
    SEL_MONTH = 2'd1,
    SEL_YEAR  = 2'd2,
    SEL_NONE  = 2'd3
  } sel_e;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
`ifdef DATE_GREGORIAN_400_EN
    return ((y[1:0] == 2'b00) && ((y % 14'd100) != '0)) || ((y % 14'd400) == '0);
`else
    return (y[1:0] == 2'b00);
`endif
  endfunction

endpackage

// File: rtl/date_counter_days_in_month.sv
// Combinational month length lookup; out-of-range months report 31.
module days_in_month
  import date_pkg::*;
(
  input  logic [MON_W-1:0] month,
  input  logic             leap,
  output logic [DAY_W-1:0] dim
);

  always_comb begin
    dim = 5'd31;
    case (month)
      MON_APR, MON_JUN, MON_SEP, MON_NOV: dim = 5'd30;
      MON_FEB:                            dim = leap ? 5'd29 : 5'd28;
      default:                            dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// Calendar stage: day/month/year counting on the hour-stage carry, manual field adjust.
// Leap rule selected by DATE_GREGORIAN_400_EN (see date_pkg).
module date_counter
  import date_pkg::*;
#(
  parameter int unsigned YEAR_MIN   = 1,
  parameter int unsigned YEAR_MAX   = 9999,
  parameter int unsigned RESET_YEAR = 2000
) (
  input  logic              clk_1Hz,
  input  logic              rst_n,
  input  logic              en_1,
  input  logic              adjust,
  input  logic [1:0]        sel,
  input  logic              up,
  input  logic              down,
  input  logic              carry_in,
  output logic [DAY_W-1:0]  day_bin,
  output logic [MON_W-1:0]  month_bin,
  output logic [YEAR_W-1:0] year_bin,
  output logic              leap,
  output logic              carry_out
);

  localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] Y_RST = YEAR_W'(RESET_YEAR);

  logic              up_q, down_q;
  logic              step_up, step_dn;
  logic [DAY_W-1:0]  dim_cur, dim_nx;
  logic [DAY_W-1:0]  day_nx, day_cl;
  logic [MON_W-1:0]  month_nx;
  logic [YEAR_W-1:0] year_nx;
  logic              leap_nx;
  logic              wrap_nx;

  assign leap    = is_leap(year_bin);
  assign leap_nx = is_leap(year_nx);

  days_in_month u_dim_cur (
    .month (month_bin),
    .leap  (leap),
    .dim   (dim_cur)
  );

  days_in_month u_dim_nx (
    .month (month_nx),
    .leap  (leap_nx),
    .dim   (dim_nx)
  );

  // Simultaneous up/down rises cancel out.
  always_comb begin
    step_up = up & ~up_q & ~(down & ~down_q);
    step_dn = down & ~down_q & ~(up & ~up_q);
  end

  always_comb begin
    day_nx   = day_bin;
    month_nx = month_bin;
    year_nx  = year_bin;
    wrap_nx  = 1'b0;
    if (adjust) begin
      case (sel_e'(sel))
        SEL_DAY: begin
          if (step_up)      day_nx = (day_bin >= dim_cur) ? 5'd1 : day_bin + 5'd1;
          else if (step_dn) day_nx = (day_bin <= 5'd1) ? dim_cur : day_bin - 5'd1;
        end
        SEL_MONTH: begin
          if (step_up)      month_nx = (month_bin >= MON_DEC) ? MON_JAN : month_bin + 4'd1;
          else if (step_dn) month_nx = (month_bin <= MON_JAN) ? MON_DEC : month_bin - 4'd1;
        end
        SEL_YEAR: begin
          if (step_up)      year_nx = (year_bin >= Y_MAX) ? Y_MIN : year_bin + 14'd1;
          else if (step_dn) year_nx = (year_bin <= Y_MIN) ? Y_MAX : year_bin - 14'd1;
        end
        default: ;
      endcase
    end else if (en_1 && carry_in) begin
      if (day_bin < dim_cur) begin
        day_nx = day_bin + 5'd1;
      end else begin
        day_nx = 5'd1;
        if (month_bin < MON_DEC) begin
          month_nx = month_bin + 4'd1;
        end else begin
          month_nx = MON_JAN;
          if (year_bin < Y_MAX) begin
            year_nx = year_bin + 14'd1;
          end else begin
            year_nx = Y_MIN;
            wrap_nx = 1'b1;
          end
        end
      end
    end
  end

  // Clamp against the length of the month being entered, so month/year steps never leave an invalid day.
  always_comb begin
    day_cl = (day_nx > dim_nx) ? dim_nx : day_nx;
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      day_bin   <= 5'd1;
      month_bin <= MON_JAN;
      year_bin  <= Y_RST;
      carry_out <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      day_bin   <= day_cl;
      month_bin <= month_nx;
      year_bin  <= year_nx;
      carry_out <= wrap_nx;
      up_q      <= up;
      down_q    <= down;
    end
  end

endmodule

// File: tb/tb_date_counter.sv
// Directed self-checking bench for date_counter; honours DATE_GREGORIAN_400_EN for the 1900 case.
module tb_date_counter;

  logic        clk_1Hz = 1'b0;
  logic        rst_n = 1'b1;
  logic        en_1 = 1'b0;
  logic        adjust = 1'b0;
  logic [1:0]  sel = 2'd3;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic        carry_in = 1'b0;
  logic [4:0]  day_bin;
  logic [3:0]  month_bin;
  logic [13:0] year_bin;
  logic        leap;
  logic        carry_out;

  int compared = 0;
  int mismatched = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  date_counter #(
    .YEAR_MIN   (1),
    .YEAR_MAX   (9999),
    .RESET_YEAR (2000)
  ) dut (
    .clk_1Hz   (clk_1Hz),
    .rst_n     (rst_n),
    .en_1      (en_1),
    .adjust    (adjust),
    .sel       (sel),
    .up        (up),
    .down      (down),
    .carry_in  (carry_in),
    .day_bin   (day_bin),
    .month_bin (month_bin),
    .year_bin  (year_bin),
    .leap      (leap),
    .carry_out (carry_out)
  );

  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic press(input logic [1:0] s, input bit inc);
    adjust = 1'b1;
    sel = s;
    if (inc) up = 1'b1;
    else down = 1'b1;
    tick();
    up = 1'b0;
    down = 1'b0;
    tick();
  endtask

  task automatic pulse();
    adjust = 1'b0;
    en_1 = 1'b1;
    carry_in = 1'b1;
    tick();
    carry_in = 1'b0;
  endtask

  // Navigates via adjust mode; loop bounds guard against a broken DUT.
  task automatic set_date(input logic [4:0] d, input logic [3:0] m, input logic [13:0] y);
    int unsigned n = 0;
    while (year_bin != y && n < 6000) begin
      press(2'd2, (y > year_bin) ? ((y - year_bin) < 14'd5000) : ((year_bin - y) >= 14'd5000));
      n++;
    end
    n = 0;
    while (month_bin != m && n < 13) begin
      press(2'd1, 1'b1);
      n++;
    end
    n = 0;
    while (day_bin != d && n < 32) begin
      press(2'd0, 1'b1);
      n++;
    end
    adjust = 1'b0;
    sel = 2'd3;
    tick();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {d, m, y}) begin
      mismatched++;
      $display("FAIL set_date: got %0d/%0d/%0d required %0d/%0d/%0d",
               day_bin, month_bin, year_bin, d, m, y);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    compared++;
    if ({day_bin, month_bin, year_bin, carry_out} !== {5'd1, 4'd1, 14'd2000, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_values: got %0d/%0d/%0d co=%b required 1/1/2000 co=0",
               day_bin, month_bin, year_bin, carry_out);
    end
    compared++;
    if (leap !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_leap: got %b required 1", leap);
    end
    @(negedge clk_1Hz);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_count_january();
    repeat (30) pulse();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd31, 4'd1, 14'd2000}) begin
      mismatched++;
      $display("FAIL jan_31: got %0d/%0d/%0d required 31/1/2000", day_bin, month_bin, year_bin);
    end
    pulse();
    compared++;
    if ({day_bin, month_bin, year_bin, carry_out} !== {5'd1, 4'd2, 14'd2000, 1'b0}) begin
      mismatched++;
      $display("FAIL feb_1: got %0d/%0d/%0d co=%b required 1/2/2000 co=0",
               day_bin, month_bin, year_bin, carry_out);
    end
  endtask

  task automatic test_leap();
    logic       exp_leap;
    logic [4:0] exp_d;
    logic [3:0] exp_m;
    set_date(5'd28, 4'd2, 14'd2000);
    pulse();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd29, 4'd2, 14'd2000}) begin
      mismatched++;
      $display("FAIL leap_2000: got %0d/%0d/%0d required 29/2/2000", day_bin, month_bin, year_bin);
    end
    pulse();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd1, 4'd3, 14'd2000}) begin
      mismatched++;
      $display("FAIL mar_2000: got %0d/%0d/%0d required 1/3/2000", day_bin, month_bin, year_bin);
    end
`ifdef DATE_GREGORIAN_400_EN
    exp_leap = 1'b0; exp_d = 5'd1;  exp_m = 4'd3;
`else
    exp_leap = 1'b1; exp_d = 5'd29; exp_m = 4'd2;
`endif
    set_date(5'd28, 4'd2, 14'd1900);
    compared++;
    if (leap !== exp_leap) begin
      mismatched++;
      $display("FAIL leap_flag_1900: got %b required %b", leap, exp_leap);
    end
    pulse();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {exp_d, exp_m, 14'd1900}) begin
      mismatched++;
      $display("FAIL feb_1900: got %0d/%0d/%0d required %0d/%0d/1900",
               day_bin, month_bin, year_bin, exp_d, exp_m);
    end
    set_date(5'd28, 4'd2, 14'd2023);
    compared++;
    if (leap !== 1'b0) begin
      mismatched++;
      $display("FAIL leap_flag_2023: got %b required 0", leap);
    end
    pulse();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd1, 4'd3, 14'd2023}) begin
      mismatched++;
      $display("FAIL mar_2023: got %0d/%0d/%0d required 1/3/2023", day_bin, month_bin, year_bin);
    end
  endtask

  task automatic test_year_wrap();
    set_date(5'd31, 4'd12, 14'd9999);
    pulse();
    compared++;
    if ({day_bin, month_bin, year_bin, carry_out} !== {5'd1, 4'd1, 14'd1, 1'b1}) begin
      mismatched++;
      $display("FAIL millennium_wrap: got %0d/%0d/%0d co=%b required 1/1/1 co=1",
               day_bin, month_bin, year_bin, carry_out);
    end
    tick();
    compared++;
    if ({day_bin, month_bin, year_bin, carry_out} !== {5'd1, 4'd1, 14'd1, 1'b0}) begin
      mismatched++;
      $display("FAIL carry_one_cycle: got %0d/%0d/%0d co=%b required 1/1/1 co=0",
               day_bin, month_bin, year_bin, carry_out);
    end
    set_date(5'd31, 4'd12, 14'd2024);
    pulse();
    compared++;
    if ({day_bin, month_bin, year_bin, carry_out} !== {5'd1, 4'd1, 14'd2025, 1'b0}) begin
      mismatched++;
      $display("FAIL new_year_2025: got %0d/%0d/%0d co=%b required 1/1/2025 co=0",
               day_bin, month_bin, year_bin, carry_out);
    end
  endtask

  task automatic test_adjust_clamp();
    set_date(5'd31, 4'd3, 14'd2024);
    adjust = 1'b1;
    sel = 2'd1;
    down = 1'b1;
    tick();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd29, 4'd2, 14'd2024}) begin
      mismatched++;
      $display("FAIL clamp_feb: got %0d/%0d/%0d required 29/2/2024", day_bin, month_bin, year_bin);
    end
    down = 1'b0;
    tick();
    up = 1'b1;
    repeat (5) tick();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd29, 4'd3, 14'd2024}) begin
      mismatched++;
      $display("FAIL held_up_single: got %0d/%0d/%0d required 29/3/2024", day_bin, month_bin, year_bin);
    end
    up = 1'b0;
    tick();
    sel = 2'd0;
    press(2'd0, 1'b1);
    press(2'd0, 1'b1);
    press(2'd0, 1'b1);
    compared++;
    if (day_bin !== 5'd1) begin
      mismatched++;
      $display("FAIL day_wrap_up: got %0d required 1", day_bin);
    end
    press(2'd0, 1'b0);
    compared++;
    if (day_bin !== 5'd31) begin
      mismatched++;
      $display("FAIL day_wrap_down: got %0d required 31", day_bin);
    end
    press(2'd3, 1'b1);
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd31, 4'd3, 14'd2024}) begin
      mismatched++;
      $display("FAIL sel_none: got %0d/%0d/%0d required 31/3/2024", day_bin, month_bin, year_bin);
    end
  endtask

  task automatic test_conflicts();
    adjust = 1'b1;
    sel = 2'd0;
    up = 1'b1;
    down = 1'b1;
    tick();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd31, 4'd3, 14'd2024}) begin
      mismatched++;
      $display("FAIL up_down_cancel: got %0d/%0d/%0d required 31/3/2024", day_bin, month_bin, year_bin);
    end
    up = 1'b0;
    down = 1'b0;
    en_1 = 1'b1;
    carry_in = 1'b1;
    tick();
    carry_in = 1'b0;
    adjust = 1'b0;
    tick();
    en_1 = 1'b0;
    carry_in = 1'b1;
    tick();
    carry_in = 1'b0;
    en_1 = 1'b1;
    tick();
    compared++;
    if ({day_bin, month_bin, year_bin, carry_out} !== {5'd31, 4'd3, 14'd2024, 1'b0}) begin
      mismatched++;
      $display("FAIL carry_dropped: got %0d/%0d/%0d co=%b required 31/3/2024 co=0",
               day_bin, month_bin, year_bin, carry_out);
    end
    sel = 2'd1;
    up = 1'b1;
    tick();
    adjust = 1'b1;
    tick();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd31, 4'd3, 14'd2024}) begin
      mismatched++;
      $display("FAIL count_mode_button: got %0d/%0d/%0d required 31/3/2024", day_bin, month_bin, year_bin);
    end
    up = 1'b0;
    adjust = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    set_date(5'd15, 4'd7, 14'd2024);
    @(posedge clk_1Hz);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({day_bin, month_bin, year_bin, carry_out} !== {5'd1, 4'd1, 14'd2000, 1'b0}) begin
      mismatched++;
      $display("FAIL async_reset: got %0d/%0d/%0d co=%b required 1/1/2000 co=0",
               day_bin, month_bin, year_bin, carry_out);
    end
    @(negedge clk_1Hz);
    rst_n = 1'b1;
    tick();
    compared++;
    if ({day_bin, month_bin, year_bin} !== {5'd1, 4'd1, 14'd2000}) begin
      mismatched++;
      $display("FAIL after_reset: got %0d/%0d/%0d required 1/1/2000", day_bin, month_bin, year_bin);
    end
  endtask

  initial begin
    test_reset();
    test_count_january();
    test_leap();
    test_year_wrap();
    test_adjust_clamp();
    test_conflicts();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
